// File: rtl/mtsp_mo_dispatch_seq.sv
// Sequential MO dispatch: latches a PHASES-wide main/sub bundle and issues one per-lane descriptor word per cycle.
// Latency: accept at edge N -> first word valid after N+1; skipped phases cost no cycles; output holds under OUT_READY low.
module mtsp_mo_dispatch_seq #(
    parameter int LANES  = 4,
    parameter int PHASES = 2,
    parameter int MO_W   = 4,
    parameter int GPR_AW = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [2*PHASES-1:0]          IN_nEN,
    input  logic [PHASES-1:0]            IN_MAIN_nALU,
    input  logic [2*PHASES*MO_W-1:0]     IN_MO,
    input  logic [2*PHASES-1:0]          IN_ALT,
    input  logic [2*PHASES-1:0]          IN_SEL,
    input  logic [PHASES*LANES-1:0]      IN_WMASK,
    input  logic [PHASES*LANES-1:0]      IN_MOMASK,
    input  logic [PHASES*(GPR_AW-2)-1:0] IN_DEST,
    input  logic [PHASES-1:0]            IN_SWITCH,
    input  logic [2*PHASES-1:0]          IN_EXT,
    input  logic [GPR_AW-1:0]            REF_ADDR_DEST,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [LANES*(MO_W+3)-1:0]    OUT_MODESC,
    output logic [LANES-1:0]             OUT_MASK,
    output logic [GPR_AW-1:0]            OUT_WADDR,
    output logic [2:0]                   OUT_PHASE,
    output logic                         OUT_LAST
);
    localparam int DW     = GPR_AW - 2;
    localparam int DESC_W = MO_W + 3;

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nxt;

    logic [2*PHASES-1:0]      b_nen;
    logic [PHASES-1:0]        b_nalu;
    logic [2*PHASES*MO_W-1:0] b_mo;
    logic [2*PHASES-1:0]      b_alt;
    logic [2*PHASES-1:0]      b_sel;
    logic [PHASES*LANES-1:0]  b_wmask;
    logic [PHASES*LANES-1:0]  b_momask;
    logic [PHASES*DW-1:0]     b_dest;
    logic [PHASES-1:0]        b_switch;
    logic [2*PHASES-1:0]      b_ext;
    logic [GPR_AW-1:0]        b_ref;
    logic [2:0]               ptr;

    logic [PHASES-1:0]        in_skip, b_skip;
    logic                     first_found, nxt_found;
    logic [2:0]               first_idx, nxt_idx;
    logic                     accept, load_ok;

    int                       pi;
    logic                     cur_sden, cur_mden;
    logic [LANES-1:0]         cur_mask;
    logic [LANES*DESC_W-1:0]  cur_desc;
    logic [1:0]               cur_ext;
    logic [GPR_AW-1:0]        cur_waddr;

    assign IN_READY = (state == IDLE) & ~RST;
    assign accept   = IN_VALID & IN_READY;
    assign load_ok  = ~OUT_VALID | OUT_READY;

    // A phase is skipped when no lane would write: main disabled, non-ALU main, or every lane masked.
    always_comb begin
        in_skip     = '0;
        b_skip      = '0;
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int p = 0; p < PHASES; p++) begin
            in_skip[p] = IN_nEN[2*p] | IN_MAIN_nALU[p] | (&IN_WMASK[p*LANES +: LANES]);
            b_skip[p]  = b_nen[2*p] | b_nalu[p] | (&b_wmask[p*LANES +: LANES]);
        end
        for (int p = PHASES - 1; p >= 0; p--) begin
            if (!in_skip[p]) begin
                first_found = 1'b1;
                first_idx   = 3'(p);
            end
            if (!b_skip[p] && (3'(p) > ptr)) begin
                nxt_found = 1'b1;
                nxt_idx   = 3'(p);
            end
        end
    end

    always_comb begin
        pi       = int'(ptr);
        cur_mden = b_nen[2*pi];
        cur_sden = b_nen[2*pi+1];
        cur_mask = '0;
        cur_desc = '0;
        for (int l = 0; l < LANES; l++) begin
            cur_mask[l] = ~cur_sden & b_momask[pi*LANES+l];
            if (cur_mask[l])
                cur_desc[l*DESC_W +: DESC_W] = {cur_mden | b_nalu[pi] | b_wmask[pi*LANES+l],
                                                b_alt[2*pi+1], b_sel[2*pi+1],
                                                b_mo[(2*pi+1)*MO_W +: MO_W]};
            else
                cur_desc[l*DESC_W +: DESC_W] = {cur_mden | b_nalu[pi] | b_wmask[pi*LANES+l],
                                                b_alt[2*pi], b_sel[2*pi],
                                                b_mo[2*pi*MO_W +: MO_W]};
        end
        cur_ext   = (cur_sden | ~b_switch[pi]) ? 2'b00 : b_ext[2*pi +: 2];
        cur_waddr = {cur_ext, b_dest[pi*DW +: DW]};
        if (pi != 0)
            cur_waddr = cur_waddr + b_ref;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept && first_found) state_nxt = ISSUE;
            ISSUE: if (load_ok && !nxt_found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            b_nen      <= '0;
            b_nalu     <= '0;
            b_mo       <= '0;
            b_alt      <= '0;
            b_sel      <= '0;
            b_wmask    <= '0;
            b_momask   <= '0;
            b_dest     <= '0;
            b_switch   <= '0;
            b_ext      <= '0;
            b_ref      <= '0;
            ptr        <= '0;
            OUT_VALID  <= 1'b0;
            OUT_MODESC <= '0;
            OUT_MASK   <= '0;
            OUT_WADDR  <= '0;
            OUT_PHASE  <= '0;
            OUT_LAST   <= 1'b0;
        end else begin
            if (accept) begin
                b_nen    <= IN_nEN;
                b_nalu   <= IN_MAIN_nALU;
                b_mo     <= IN_MO;
                b_alt    <= IN_ALT;
                b_sel    <= IN_SEL;
                b_wmask  <= IN_WMASK;
                b_momask <= IN_MOMASK;
                b_dest   <= IN_DEST;
                b_switch <= IN_SWITCH;
                b_ext    <= IN_EXT;
                b_ref    <= REF_ADDR_DEST;
                ptr      <= first_idx;
            end
            // In IDLE a load only retires the pending word; data fields keep their last value.
            if (load_ok) begin
                OUT_VALID <= (state == ISSUE);
                if (state == ISSUE) begin
                    OUT_MODESC <= cur_desc;
                    OUT_MASK   <= cur_mask;
                    OUT_WADDR  <= cur_waddr;
                    OUT_PHASE  <= ptr;
                    OUT_LAST   <= ~nxt_found;
                    ptr        <= nxt_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_mtsp_mo_dispatch_seq.sv
// Scoreboard bench for mtsp_mo_dispatch_seq (LANES=4, PHASES=4, MO_W=4, GPR_AW=8): directed cases then random bundles.
module tb_mtsp_mo_dispatch_seq;
    localparam int LANES = 4, PHASES = 4, MO_W = 4, GPR_AW = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  IN_nEN = '0;
    logic [3:0]  IN_MAIN_nALU = '0;
    logic [31:0] IN_MO = '0;
    logic [7:0]  IN_ALT = '0, IN_SEL = '0;
    logic [15:0] IN_WMASK = '0, IN_MOMASK = '0;
    logic [23:0] IN_DEST = '0;
    logic [3:0]  IN_SWITCH = '0;
    logic [7:0]  IN_EXT = '0;
    logic [7:0]  REF_ADDR_DEST = '0;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [27:0] OUT_MODESC;
    logic [3:0]  OUT_MASK;
    logic [7:0]  OUT_WADDR;
    logic [2:0]  OUT_PHASE;
    logic        OUT_LAST;

    mtsp_mo_dispatch_seq #(.LANES(LANES), .PHASES(PHASES), .MO_W(MO_W), .GPR_AW(GPR_AW)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_nEN(IN_nEN), .IN_MAIN_nALU(IN_MAIN_nALU), .IN_MO(IN_MO), .IN_ALT(IN_ALT),
        .IN_SEL(IN_SEL), .IN_WMASK(IN_WMASK), .IN_MOMASK(IN_MOMASK), .IN_DEST(IN_DEST),
        .IN_SWITCH(IN_SWITCH), .IN_EXT(IN_EXT), .REF_ADDR_DEST(REF_ADDR_DEST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_MODESC(OUT_MODESC),
        .OUT_MASK(OUT_MASK), .OUT_WADDR(OUT_WADDR), .OUT_PHASE(OUT_PHASE), .OUT_LAST(OUT_LAST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       main_dis, sub_dis, nalu, alt_m, alt_s, sel_m, sel_s, sw;
        bit [3:0] mo_m, mo_s, wmask, momask;
        bit [5:0] dest;
        bit [1:0] ext;
    } ph_t;

    typedef struct packed {
        logic [27:0] desc;
        logic [3:0]  mask;
        logic [7:0]  waddr;
        logic [2:0]  phase;
        logic        last;
    } word_t;

    ph_t    cur[PHASES];
    bit [7:0] cur_ref;
    word_t  sb[$];
    int     tests = 0, fails = 0;
    bit     rand_rdy = 1'b0, force_rdy = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: list the phases that have any writing lane, then emit one word for each in order.
    function automatic void push_expected();
        int live[$];
        for (int p = 0; p < PHASES; p++) begin
            bit any = 0;
            for (int l = 0; l < LANES; l++)
                if (!(cur[p].main_dis || cur[p].nalu || cur[p].wmask[l])) any = 1;
            if (any) live.push_back(p);
        end
        for (int k = 0; k < live.size(); k++) begin
            word_t w;
            ph_t c;
            int a;
            c = cur[live[k]];
            w = '0;
            for (int l = 0; l < LANES; l++) begin
                bit sub = !c.sub_dis && c.momask[l];
                bit nen = c.main_dis || c.nalu || c.wmask[l];
                w.mask[l] = sub;
                w.desc[l*7 +: 7] = sub ? {nen, c.alt_s, c.sel_s, c.mo_s} : {nen, c.alt_m, c.sel_m, c.mo_m};
            end
            a = ((c.sub_dis || !c.sw) ? 0 : int'(c.ext)) * 64 + int'(c.dest);
            if (live[k] > 0) a = (a + int'(cur_ref)) % 256;
            w.waddr = 8'(a);
            w.phase = 3'(live[k]);
            w.last  = (k == live.size() - 1);
            sb.push_back(w);
        end
    endfunction

    function automatic void clear_bundle();
        for (int p = 0; p < PHASES; p++) begin
            cur[p] = '{default: 0};
            cur[p].main_dis = 1;
            cur[p].sub_dis  = 1;
            cur[p].wmask    = 4'hF;
        end
        cur_ref = 8'h00;
    endfunction

    function automatic void enable_phase(int p, bit [3:0] mo, bit [5:0] dest);
        cur[p].main_dis = 0;
        cur[p].wmask    = 4'h0;
        cur[p].mo_m     = mo;
        cur[p].dest     = dest;
    endfunction

    task automatic send();
        int n = 0;
        @(negedge CLK);
        while (!IN_READY && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            tests++; fails++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 500 cycles");
            return;
        end
        for (int p = 0; p < PHASES; p++) begin
            IN_nEN[2*p] = cur[p].main_dis;  IN_nEN[2*p+1] = cur[p].sub_dis;
            IN_MAIN_nALU[p] = cur[p].nalu;
            IN_MO[2*p*4 +: 4] = cur[p].mo_m; IN_MO[(2*p+1)*4 +: 4] = cur[p].mo_s;
            IN_ALT[2*p] = cur[p].alt_m; IN_ALT[2*p+1] = cur[p].alt_s;
            IN_SEL[2*p] = cur[p].sel_m; IN_SEL[2*p+1] = cur[p].sel_s;
            IN_WMASK[p*4 +: 4] = cur[p].wmask; IN_MOMASK[p*4 +: 4] = cur[p].momask;
            IN_DEST[p*6 +: 6] = cur[p].dest;
            IN_SWITCH[p] = cur[p].sw;
            IN_EXT[2*p +: 2] = cur[p].ext;
        end
        REF_ADDR_DEST = cur_ref;
        IN_VALID = 1'b1;
        @(posedge CLK);
        push_expected();
        #1;
        IN_VALID = 1'b0;
        // Scramble inputs after accept; the DUT must ignore them.
        IN_nEN = 8'($urandom); IN_MAIN_nALU = 4'($urandom); IN_MO = $urandom;
        IN_ALT = 8'($urandom); IN_SEL = 8'($urandom); IN_WMASK = 16'($urandom);
        IN_MOMASK = 16'($urandom); IN_DEST = 24'($urandom); IN_SWITCH = 4'($urandom);
        IN_EXT = 8'($urandom); REF_ADDR_DEST = 8'($urandom);
    endtask

    task automatic wait_word(input int ph, input string nm);
        int n = 0;
        @(negedge CLK);
        while (!(OUT_VALID && OUT_PHASE == 3'(ph)) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!(OUT_VALID && OUT_PHASE == 3'(ph))) begin
            tests++; fails++;
            $display("FAIL %s: phase %0d word not seen within 50 cycles (valid=%0d phase=%0d)", nm, ph, OUT_VALID, OUT_PHASE);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || OUT_VALID) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0 || OUT_VALID) begin
            tests++; fails++;
            $display("FAIL drain: %0d words outstanding, valid=%0d, expected 0", sb.size(), OUT_VALID);
        end
    endtask

    // OUT_READY changes just after the rising edge so the negedge monitor sees a stable value.
    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            OUT_READY = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
        end
    end

    initial begin
        bit    held = 0;
        word_t hold_w, act, exp;
        forever begin
            @(negedge CLK);
            if (RST) begin
                held = 0;
            end else begin
                act = {OUT_MODESC, OUT_MASK, OUT_WADDR, OUT_PHASE, OUT_LAST};
                if (held) begin
                    tests++;
                    if (!OUT_VALID || act !== hold_w) begin
                        fails++;
                        $display("FAIL stall_hold: got valid=%0d word=%h expected valid=1 word=%h", OUT_VALID, act, hold_w);
                    end
                end
                if (OUT_VALID && OUT_READY) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got %h expected no word", act);
                    end else begin
                        exp = sb.pop_front();
                        if (act !== exp) begin
                            fails++;
                            $display("FAIL word: got %h expected %h", act, exp);
                        end
                    end
                end
                held   = OUT_VALID && !OUT_READY;
                hold_w = act;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_bundle();
        #1;
        chk("reset_out_valid", 64'(OUT_VALID), 64'd0);
        chk("reset_in_ready", 64'(IN_READY), 64'd0);
        chk("reset_out_modesc", 64'(OUT_MODESC), 64'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_in_ready", 64'(IN_READY), 64'd1);

        // Single enabled phase, 1-cycle latency
        clear_bundle();
        enable_phase(0, 4'd3, 6'h15);
        cur[0].alt_m = 1; cur[0].sw = 1; cur[0].ext = 2'b11;
        send();
        @(negedge CLK);
        chk("lat_not_early", 64'(OUT_VALID), 64'd0);
        @(negedge CLK);
        chk("lat_valid", 64'(OUT_VALID), 64'd1);
        chk("single_desc", 64'(OUT_MODESC), 64'({4{7'h23}}));
        chk("single_waddr", 64'(OUT_WADDR), 64'h15);
        chk("single_phase_last", 64'({OUT_PHASE, OUT_LAST}), 64'({3'd0, 1'b1}));
        chk("single_in_ready", 64'(IN_READY), 64'd1);
        wait_drain();

        // Sub merge, then same with sub disabled
        for (int s = 0; s < 2; s++) begin
            clear_bundle();
            enable_phase(0, 4'd2, 6'h10);
            cur[0].mo_s = 4'd9; cur[0].momask = 4'b0101; cur[0].sub_dis = (s == 1);
            send();
            wait_word(0, "merge");
            chk(s == 0 ? "merge_mask" : "subdis_mask", 64'(OUT_MASK), s == 0 ? 64'h5 : 64'h0);
            chk(s == 0 ? "merge_desc" : "subdis_desc", 64'(OUT_MODESC),
                s == 0 ? 64'({7'h02, 7'h09, 7'h02, 7'h09}) : 64'({4{7'h02}}));
            wait_drain();
        end

        // Relative address wrap
        clear_bundle();
        enable_phase(0, 4'd1, 6'h01);
        enable_phase(1, 4'd4, 6'h3F);
        cur[1].sw = 1; cur[1].ext = 2'b11; cur[1].sub_dis = 0;
        cur_ref = 8'h05;
        send();
        wait_word(1, "wrap");
        chk("wrap_waddr", 64'(OUT_WADDR), 64'h04);
        chk("wrap_last", 64'(OUT_LAST), 64'd1);
        wait_drain();

        // Backpressure on word 1 of a four-phase bundle
        clear_bundle();
        for (int p = 0; p < PHASES; p++) enable_phase(p, 4'(p + 1), 6'(p * 3));
        send();
        wait_word(0, "bp");
        chk("bp_first_not_last", 64'(OUT_LAST), 64'd0);
        force_rdy = 1'b0;
        wait_word(1, "bp");
        for (int i = 0; i < 3; i++) begin
            chk("bp_held_phase", 64'({OUT_VALID, OUT_PHASE}), 64'({1'b1, 3'd1}));
            @(negedge CLK);
        end
        force_rdy = 1'b1;
        wait_word(2, "bp");
        chk("bp_busy_in_ready", 64'(IN_READY), 64'd0);
        wait_word(3, "bp");
        chk("bp_last", 64'(OUT_LAST), 64'd1);
        chk("bp_in_ready_after_last", 64'(IN_READY), 64'd1);
        wait_drain();

        // Skip phase 0 (non-ALU main)
        clear_bundle();
        enable_phase(0, 4'd5, 6'h02);
        cur[0].nalu = 1;
        enable_phase(1, 4'd6, 6'h03);
        send();
        begin
            int n = 0;
            @(negedge CLK);
            while (!OUT_VALID && n < 20) begin @(negedge CLK); n++; end
        end
        chk("skip_phase_last", 64'({OUT_VALID, OUT_PHASE, OUT_LAST}), 64'({1'b1, 3'd1, 1'b1}));
        wait_drain();

        // All phases masked
        clear_bundle();
        cur[2].main_dis = 0; cur[2].wmask = 4'hF;
        send();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("allskip_idle", 64'({OUT_VALID, IN_READY}), 64'({1'b0, 1'b1}));
        end

        // Reset mid-bundle
        clear_bundle();
        for (int p = 0; p < PHASES; p++) enable_phase(p, 4'hA, 6'(p));
        send();
        wait_word(1, "rst");
        RST = 1'b1;
        #1;
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        sb.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_rst_idle", 64'({OUT_VALID, IN_READY}), 64'({1'b0, 1'b1}));
        end

        // Random bundles with random backpressure
        rand_rdy = 1'b1;
        for (int b = 0; b < 80; b++) begin
            for (int p = 0; p < PHASES; p++) begin
                cur[p].main_dis = ($urandom_range(0, 4) == 0);
                cur[p].sub_dis  = ($urandom_range(0, 2) == 0);
                cur[p].nalu     = ($urandom_range(0, 5) == 0);
                cur[p].wmask    = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
                cur[p].momask   = 4'($urandom);
                cur[p].mo_m     = 4'($urandom); cur[p].mo_s = 4'($urandom);
                cur[p].alt_m    = 1'($urandom); cur[p].alt_s = 1'($urandom);
                cur[p].sel_m    = 1'($urandom); cur[p].sel_s = 1'($urandom);
                cur[p].dest     = 6'($urandom);
                cur[p].sw       = 1'($urandom);
                cur[p].ext      = 2'($urandom);
            end
            cur_ref = 8'($urandom);
            send();
        end
        rand_rdy = 1'b0;
        force_rdy = 1'b1;
        @(negedge CLK);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
